iqueue_dispatcher: RTL and testbench

In-order instruction dispatcher sitting directly upstream of the execution units. Buffers decoded `type_iqueue_entry` instructions in a circular FIFO. Each cycle it issues up to `NUM_PARALLEL_INSTR_DISPATCHES` head entries, choosing a target EU for each by round robin over the ready units. It drives the `dispatched_instr_*` inputs of every EU and consumes each EU's `ready_for_next_instrs_o`.

---
 rtl/iqueue_dispatcher.sv | 173 +++++++++++++++++
 tb/tb_iqueue_dispatcher.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iqueue_dispatcher.sv
// In-order instruction dispatcher: circular FIFO of decoded instructions that
// issues up to NUM_PARALLEL_INSTR_DISPATCHES head entries per cycle, picking a
// target execution unit for each by round robin over the ready units.

`ifndef NUM_PARALLEL_INSTR_DISPATCHES
`define NUM_PARALLEL_INSTR_DISPATCHES 2
`endif

`ifndef LOG2_NUM_EXEC_UNITS
`define LOG2_NUM_EXEC_UNITS 2
`endif

package iqueue_pkg;
    typedef logic [31:0] type_iqueue_entry;
endpackage

module iqueue_dispatcher
    import iqueue_pkg::*;
#(
    parameter int NUM_PARALLEL_INSTR_DISPATCHES = `NUM_PARALLEL_INSTR_DISPATCHES,
    parameter int NUM_EXEC_UNITS                = 4,
    parameter int LOG2_NUM_EXEC_UNITS           = `LOG2_NUM_EXEC_UNITS,
    parameter int DEPTH                         = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  type_iqueue_entry         enq_instr_i,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  logic [NUM_EXEC_UNITS-1:0] eu_ready_i,
    output type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0] dispatched_instr_o,
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0] dispatched_instr_valid_o,
    output logic [LOG2_NUM_EXEC_UNITS-1:0][NUM_PARALLEL_INSTR_DISPATCHES-1:0] dispatched_instr_alloc_euidx_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int N  = NUM_PARALLEL_INSTR_DISPATCHES;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = LOG2_NUM_EXEC_UNITS;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW-1:0]         count;
    type_iqueue_entry      mem [DEPTH];

    logic [EW-1:0]         rr_ptr;
    logic [NUM_EXEC_UNITS-1:0] blackout;
    logic [NUM_EXEC_UNITS-1:0] eligible;
    logic [NUM_EXEC_UNITS-1:0] taken;

    logic [N-1:0]          slot_valid;
    logic [EW-1:0]         slot_eu [N];
    logic [AW-1:0]         rd_idx [N];
    logic [PW-1:0]         alloc_cnt;
    logic [EW-1:0]         next_rr;
    logic                  enq_fire;

    logic                  stop;
    logic                  found;
    logic [EW-1:0]         pick;
    logic [EW-1:0]         cand;

    assign count       = tail - head;
    assign occupancy_o = count;

    // Enqueue admission uses the registered count only, so a dispatch in the
    // same cycle never frees a slot for an incoming instruction.
    assign enq_ready_o = (count < PW'(DEPTH)) && !flush_i;
    assign enq_fire    = enq_valid_i && enq_ready_o;

    // An EU that was handed an instruction last cycle is skipped this cycle,
    // giving its registered ready flag time to reflect the new work.
    assign eligible = eu_ready_i & ~blackout;

    // FIFO read addresses for each slot, wrapping naturally at DEPTH.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            rd_idx[k] = head[AW-1:0] + AW'(k);
        end
    end

    // Slot allocation: contiguous from slot 0, each slot takes the first
    // eligible unclaimed EU from rr_ptr upward; the first miss ends the scan.
    always_comb begin
        taken      = '0;
        slot_valid = '0;
        alloc_cnt  = '0;
        next_rr    = rr_ptr;
        stop       = 1'b0;
        found      = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = 0; k < N; k++) begin
            slot_eu[k] = '0;
        end
        for (int k = 0; k < N; k++) begin
            found = 1'b0;
            pick  = '0;
            if (!stop && !flush_i && (PW'(k) < count)) begin
                for (int j = 0; j < NUM_EXEC_UNITS; j++) begin
                    cand = EW'((int'(rr_ptr) + j) % NUM_EXEC_UNITS);
                    if (!found && eligible[cand] && !taken[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end
                end
            end
            if (found) begin
                slot_valid[k] = 1'b1;
                slot_eu[k]    = pick;
                taken[pick]   = 1'b1;
                alloc_cnt     = alloc_cnt + PW'(1);
                next_rr       = EW'((int'(pick) + 1) % NUM_EXEC_UNITS);
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Instruction storage; contents need no reset because valid tracking
    // lives entirely in the pointers.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail[AW-1:0]] <= enq_instr_i;
        end
    end

    // Queue pointers, round-robin position and blackout mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head     <= '0;
            tail     <= '0;
            rr_ptr   <= '0;
            blackout <= '0;
        end else if (flush_i) begin
            head     <= '0;
            tail     <= '0;
            rr_ptr   <= '0;
            blackout <= '0;
        end else begin
            head     <= head + alloc_cnt;
            tail     <= tail + PW'(enq_fire);
            rr_ptr   <= next_rr;
            blackout <= taken;
        end
    end

    // Registered dispatch outputs; idle slots are driven to zero. The euidx
    // port is bit-major: [index bit][slot].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dispatched_instr_valid_o       <= '0;
            dispatched_instr_o             <= '0;
            dispatched_instr_alloc_euidx_o <= '0;
        end else if (flush_i) begin
            dispatched_instr_valid_o       <= '0;
            dispatched_instr_o             <= '0;
            dispatched_instr_alloc_euidx_o <= '0;
        end else begin
            dispatched_instr_valid_o <= slot_valid;
            for (int k = 0; k < N; k++) begin
                dispatched_instr_o[k] <= slot_valid[k] ? mem[rd_idx[k]] : '0;
                for (int b = 0; b < EW; b++) begin
                    dispatched_instr_alloc_euidx_o[b][k] <= slot_eu[k][b];
                end
            end
        end
    end

endmodule

// File: tb/tb_iqueue_dispatcher.sv
// Directed testbench for iqueue_dispatcher: each task drives one scenario and
// compares registered outputs against hand-computed values.

module tb_iqueue_dispatcher;
    import iqueue_pkg::*;

    localparam int N  = 2;
    localparam int NE = 4;
    localparam int EW = 2;
    localparam int D  = 8;

    logic                     clk;
    logic                     reset_n;
    logic                     flush_i;
    type_iqueue_entry         enq_instr_i;
    logic                     enq_valid_i;
    logic                     enq_ready_o;
    logic [NE-1:0]            eu_ready_i;
    type_iqueue_entry [N-1:0] dispatched_instr_o;
    logic [N-1:0]             dispatched_instr_valid_o;
    logic [EW-1:0][N-1:0]     dispatched_instr_alloc_euidx_o;
    logic [$clog2(D):0]       occupancy_o;

    int checks;
    int errors;

    iqueue_dispatcher #(
        .NUM_PARALLEL_INSTR_DISPATCHES(N),
        .NUM_EXEC_UNITS(NE),
        .LOG2_NUM_EXEC_UNITS(EW),
        .DEPTH(D)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush_i(flush_i),
        .enq_instr_i(enq_instr_i),
        .enq_valid_i(enq_valid_i),
        .enq_ready_o(enq_ready_o),
        .eu_ready_i(eu_ready_i),
        .dispatched_instr_o(dispatched_instr_o),
        .dispatched_instr_valid_o(dispatched_instr_valid_o),
        .dispatched_instr_alloc_euidx_o(dispatched_instr_alloc_euidx_o),
        .occupancy_o(occupancy_o)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reassembles the EU index for one slot from the bit-major output port.
    function automatic logic [EW-1:0] eu_of(input int k);
        logic [EW-1:0] r;
        for (int b = 0; b < EW; b++) r[b] = dispatched_instr_alloc_euidx_o[b][k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        enq_instr_i = '0;
        eu_ready_i  = '0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        enq_instr_i = '0;
        eu_ready_i  = 4'hF;
        #7;
        checks++;
        if (dispatched_instr_valid_o !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_valid: got %b expected 00", dispatched_instr_valid_o);
        end
        checks++;
        if (dispatched_instr_o !== '0) begin
            errors++; $display("[TB] FAIL reset_data: got %h expected 0", dispatched_instr_o);
        end
        checks++;
        if (dispatched_instr_alloc_euidx_o !== '0) begin
            errors++; $display("[TB] FAIL reset_euidx: got %h expected 0", dispatched_instr_alloc_euidx_o);
        end
        checks++;
        if (occupancy_o !== 4'd0) begin
            errors++; $display("[TB] FAIL reset_occ: got %0d expected 0", occupancy_o);
        end
        checks++;
        if (enq_ready_o !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_enq_ready: got %b expected 1", enq_ready_o);
        end
    endtask

    task automatic test_basic_dispatch();
        do_reset();
        enq_valid_i = 1'b1; enq_instr_i = 32'hAAAA_0001;
        tick();
        enq_instr_i = 32'hBBBB_0002;
        tick();
        enq_valid_i = 1'b0; eu_ready_i = 4'hF;
        checks++;
        if (occupancy_o !== 4'd2) begin
            errors++; $display("[TB] FAIL basic_occ2: got %0d expected 2", occupancy_o);
        end
        tick();
        checks++;
        if (dispatched_instr_valid_o !== 2'b11) begin
            errors++; $display("[TB] FAIL basic_valid: got %b expected 11", dispatched_instr_valid_o);
        end
        checks++;
        if (dispatched_instr_o[0] !== 32'hAAAA_0001 || dispatched_instr_o[1] !== 32'hBBBB_0002) begin
            errors++; $display("[TB] FAIL basic_data: got %h/%h expected aaaa0001/bbbb0002",
                               dispatched_instr_o[0], dispatched_instr_o[1]);
        end
        checks++;
        if (eu_of(0) !== 2'd0 || eu_of(1) !== 2'd1) begin
            errors++; $display("[TB] FAIL basic_euidx: got %0d/%0d expected 0/1", eu_of(0), eu_of(1));
        end
        checks++;
        if (occupancy_o !== 4'd0) begin
            errors++; $display("[TB] FAIL basic_occ0: got %0d expected 0", occupancy_o);
        end
        tick();
        checks++;
        if (dispatched_instr_valid_o !== 2'b00 || dispatched_instr_o !== '0) begin
            errors++; $display("[TB] FAIL basic_one_cycle: got valid %b data %h expected 00/0",
                               dispatched_instr_valid_o, dispatched_instr_o);
        end
    endtask

    task automatic test_full_fifo();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            enq_valid_i = 1'b1;
            enq_instr_i = 32'hF000_0000 + 32'(i);
            #1;
            checks++;
            if (enq_ready_o !== (i < 8)) begin
                errors++; $display("[TB] FAIL full_enq_ready_%0d: got %b expected %b", i, enq_ready_o, (i < 8));
            end
            tick();
        end
        checks++;
        if (occupancy_o !== 4'd8) begin
            errors++; $display("[TB] FAIL full_occ: got %0d expected 8", occupancy_o);
        end
        eu_ready_i = 4'b0001;
        #1;
        checks++;
        if (enq_ready_o !== 1'b0) begin
            errors++; $display("[TB] FAIL full_no_credit: got %b expected 0", enq_ready_o);
        end
        tick();
        enq_valid_i = 1'b0;
        checks++;
        if (dispatched_instr_valid_o !== 2'b01 || dispatched_instr_o[0] !== 32'hF000_0000 || eu_of(0) !== 2'd0) begin
            errors++; $display("[TB] FAIL full_drain_first: got valid %b data %h eu %0d expected 01/f0000000/0",
                               dispatched_instr_valid_o, dispatched_instr_o[0], eu_of(0));
        end
        checks++;
        if (occupancy_o !== 4'd7 || enq_ready_o !== 1'b1) begin
            errors++; $display("[TB] FAIL full_after: got occ %0d ready %b expected 7/1", occupancy_o, enq_ready_o);
        end
    endtask

    task automatic test_single_eu_blackout();
        logic [N-1:0]     exp_v [5];
        type_iqueue_entry exp_d [5];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            enq_valid_i = 1'b1;
            enq_instr_i = 32'hB100_0000 + 32'(i);
            tick();
        end
        enq_valid_i = 1'b0;
        eu_ready_i  = 4'b0100;
        exp_v = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        exp_d = '{32'hB100_0000, 32'h0, 32'hB100_0001, 32'h0, 32'hB100_0002};
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (dispatched_instr_valid_o !== exp_v[c] || dispatched_instr_o[0] !== exp_d[c] ||
                eu_of(0) !== (exp_v[c][0] ? 2'd2 : 2'd0)) begin
                errors++; $display("[TB] FAIL blackout_cycle%0d: got valid %b data %h eu %0d expected %b/%h/%0d",
                                   c + 1, dispatched_instr_valid_o, dispatched_instr_o[0], eu_of(0),
                                   exp_v[c], exp_d[c], (exp_v[c][0] ? 2 : 0));
            end
        end
        checks++;
        if (occupancy_o !== 4'd0) begin
            errors++; $display("[TB] FAIL blackout_occ: got %0d expected 0", occupancy_o);
        end
    endtask

    task automatic test_round_robin_wrap();
        logic [N-1:0] exp_v [4];
        logic [EW-1:0] exp_e0 [4];
        logic [EW-1:0] exp_e1 [4];
        do_reset();
        for (int i = 0; i < 7; i++) begin
            enq_valid_i = 1'b1;
            enq_instr_i = 32'hC000_0000 + 32'(i);
            tick();
        end
        enq_valid_i = 1'b0;
        eu_ready_i  = 4'hF;
        exp_v  = '{2'b11, 2'b11, 2'b11, 2'b01};
        exp_e0 = '{2'd0, 2'd2, 2'd0, 2'd2};
        exp_e1 = '{2'd1, 2'd3, 2'd1, 2'd0};
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (dispatched_instr_valid_o !== exp_v[c] || eu_of(0) !== exp_e0[c] || eu_of(1) !== exp_e1[c] ||
                dispatched_instr_o[0] !== 32'hC000_0000 + 32'(2 * c)) begin
                errors++; $display("[TB] FAIL rr_step%0d: got valid %b eu %0d/%0d data0 %h expected %b %0d/%0d %h",
                                   c, dispatched_instr_valid_o, eu_of(0), eu_of(1), dispatched_instr_o[0],
                                   exp_v[c], exp_e0[c], exp_e1[c], 32'hC000_0000 + 32'(2 * c));
            end
        end
        eu_ready_i  = 4'h0;
        enq_valid_i = 1'b1; enq_instr_i = 32'h0000_00A1;
        tick();
        enq_instr_i = 32'h0000_00B2;
        tick();
        enq_valid_i = 1'b0; eu_ready_i = 4'hF;
        tick();
        checks++;
        if (dispatched_instr_valid_o !== 2'b11 || dispatched_instr_o[0] !== 32'h0000_00A1 ||
            dispatched_instr_o[1] !== 32'h0000_00B2) begin
            errors++; $display("[TB] FAIL wrap_data: got valid %b data %h/%h expected 11 a1/b2",
                               dispatched_instr_valid_o, dispatched_instr_o[0], dispatched_instr_o[1]);
        end
        checks++;
        if (eu_of(0) !== 2'd3 || eu_of(1) !== 2'd0) begin
            errors++; $display("[TB] FAIL wrap_euidx: got %0d/%0d expected 3/0", eu_of(0), eu_of(1));
        end
        enq_valid_i = 1'b1; enq_instr_i = 32'h0000_00C3;
        tick();
        enq_valid_i = 1'b0;
        tick();
        checks++;
        if (dispatched_instr_valid_o !== 2'b01 || eu_of(0) !== 2'd1 || dispatched_instr_o[0] !== 32'h0000_00C3) begin
            errors++; $display("[TB] FAIL rr_after_wrap: got valid %b eu %0d data %h expected 01/1/c3",
                               dispatched_instr_valid_o, eu_of(0), dispatched_instr_o[0]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            enq_valid_i = 1'b1;
            enq_instr_i = 32'hD000_0000 + 32'(i);
            tick();
        end
        checks++;
        if (occupancy_o !== 4'd5) begin
            errors++; $display("[TB] FAIL flush_pre_occ: got %0d expected 5", occupancy_o);
        end
        flush_i = 1'b1; enq_valid_i = 1'b1; enq_instr_i = 32'hDEAD_0000; eu_ready_i = 4'hF;
        #1;
        checks++;
        if (enq_ready_o !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_enq_ready: got %b expected 0", enq_ready_o);
        end
        tick();
        flush_i = 1'b0; enq_valid_i = 1'b0;
        checks++;
        if (dispatched_instr_valid_o !== 2'b00 || occupancy_o !== 4'd0) begin
            errors++; $display("[TB] FAIL flush_clear: got valid %b occ %0d expected 00/0",
                               dispatched_instr_valid_o, occupancy_o);
        end
        tick();
        checks++;
        if (dispatched_instr_valid_o !== 2'b00 || occupancy_o !== 4'd0) begin
            errors++; $display("[TB] FAIL flush_dropped: got valid %b occ %0d expected 00/0",
                               dispatched_instr_valid_o, occupancy_o);
        end
    endtask

    task automatic test_reset_mid_operation();
        do_reset();
        enq_valid_i = 1'b1; enq_instr_i = 32'hE000_0001;
        tick();
        enq_instr_i = 32'hE000_0002;
        tick();
        enq_valid_i = 1'b1; enq_instr_i = 32'hE000_0003; eu_ready_i = 4'hF;
        tick();
        enq_valid_i = 1'b0;
        checks++;
        if (dispatched_instr_valid_o !== 2'b11) begin
            errors++; $display("[TB] FAIL midrst_pre_valid: got %b expected 11", dispatched_instr_valid_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dispatched_instr_valid_o !== 2'b00 || dispatched_instr_o !== '0 ||
            dispatched_instr_alloc_euidx_o !== '0) begin
            errors++; $display("[TB] FAIL midrst_async: got valid %b data %h euidx %h expected all 0",
                               dispatched_instr_valid_o, dispatched_instr_o, dispatched_instr_alloc_euidx_o);
        end
        checks++;
        if (occupancy_o !== 4'd0 || enq_ready_o !== 1'b1) begin
            errors++; $display("[TB] FAIL midrst_occ: got occ %0d ready %b expected 0/1", occupancy_o, enq_ready_o);
        end
        @(negedge clk);
        reset_n = 1'b1; eu_ready_i = 4'h0;
        enq_valid_i = 1'b1; enq_instr_i = 32'hE000_0004;
        tick();
        enq_valid_i = 1'b0;
        checks++;
        if (occupancy_o !== 4'd1) begin
            errors++; $display("[TB] FAIL midrst_first_enq: got occ %0d expected 1", occupancy_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_dispatch();
        test_full_fifo();
        test_single_eu_blackout();
        test_round_robin_wrap();
        test_flush();
        test_reset_mid_operation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
